// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit adder among NUM_REQ requesters, with a one-entry tagged result register.
// Optional feature macro: ADDER_ARB_FLAGS_EN adds registered resp_carry / resp_ovf outputs.
module adder_share_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 64,
    parameter int ID_W    = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    output logic                     resp_valid,
    input  logic                     resp_ready,
    output logic [ID_W-1:0]          resp_id,
    output logic [WIDTH-1:0]         resp_sum,
`ifdef ADDER_ARB_FLAGS_EN
    output logic                     resp_carry,
    output logic                     resp_ovf,
`endif
    output logic [31:0]              grant_count
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   resp_id_q, resp_id_d;
    logic [WIDTH-1:0]  resp_sum_q, resp_sum_d;
    logic [31:0]       grant_count_q, grant_count_d;
`ifdef ADDER_ARB_FLAGS_EN
    logic              resp_carry_q, resp_carry_d;
    logic              resp_ovf_q, resp_ovf_d;
    logic [WIDTH:0]    sum_ext;
`endif

    logic [WIDTH-1:0]  a_arr [NUM_REQ];
    logic [WIDTH-1:0]  b_arr [NUM_REQ];
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [WIDTH-1:0]  sum_val;
    logic              can_accept;
    logic              grant_found;
    logic              grant_valid;
    logic [ID_W-1:0]   grant_idx;
    logic [ID_W:0]     scan_idx;
    logic [ID_W:0]     ptr_inc;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign a_arr[gi] = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi] = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

    assign can_accept = (state_q == ST_EMPTY) || ((state_q == ST_FULL) && resp_ready);

    // Scan requesters starting at rr_ptr, wrapping modulo NUM_REQ; first valid wins.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
            if (scan_idx >= (ID_W+1)'(NUM_REQ)) begin
                scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!grant_found && req_valid[scan_idx[ID_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_idx[ID_W-1:0];
            end
        end
    end

    // A grant in a reset cycle is suppressed so no requester sees a handshake.
    assign grant_valid = can_accept && grant_found && !reset;

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                a_sel = a_arr[i];
                b_sel = b_arr[i];
            end
        end
    end

`ifdef ADDER_ARB_FLAGS_EN
    assign sum_ext = {1'b0, a_sel} + {1'b0, b_sel};
    assign sum_val = sum_ext[WIDTH-1:0];
`else
    assign sum_val = a_sel + b_sel;
`endif

    assign ptr_inc = {1'b0, grant_idx} + (ID_W+1)'(1);

    // FSM: state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next-state logic
    always_comb begin
        state_d = state_q;
        if (grant_valid) begin
            state_d = ST_FULL;
        end else if ((state_q == ST_FULL) && resp_ready) begin
            state_d = ST_EMPTY;
        end
    end

    // FSM: outputs
    always_comb begin
        resp_valid = (state_q == ST_FULL);
        req_ready  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_valid && (grant_idx == ID_W'(i));
        end
    end

    // Datapath next values: only a grant changes the result and pointer; a drain leaves stale data.
    always_comb begin
        rr_ptr_d      = rr_ptr_q;
        resp_id_d     = resp_id_q;
        resp_sum_d    = resp_sum_q;
        grant_count_d = grant_count_q;
`ifdef ADDER_ARB_FLAGS_EN
        resp_carry_d  = resp_carry_q;
        resp_ovf_d    = resp_ovf_q;
`endif
        if (grant_valid) begin
            resp_id_d  = grant_idx;
            resp_sum_d = sum_val;
            rr_ptr_d   = (ptr_inc >= (ID_W+1)'(NUM_REQ)) ? '0 : ptr_inc[ID_W-1:0];
            if (grant_count_q != 32'hFFFF_FFFF) begin
                grant_count_d = grant_count_q + 32'd1;
            end
`ifdef ADDER_ARB_FLAGS_EN
            resp_carry_d = sum_ext[WIDTH];
            resp_ovf_d   = (a_sel[WIDTH-1] == b_sel[WIDTH-1]) &&
                           (sum_val[WIDTH-1] != a_sel[WIDTH-1]);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q      <= '0;
            resp_id_q     <= '0;
            resp_sum_q    <= '0;
            grant_count_q <= '0;
`ifdef ADDER_ARB_FLAGS_EN
            resp_carry_q  <= 1'b0;
            resp_ovf_q    <= 1'b0;
`endif
        end else begin
            rr_ptr_q      <= rr_ptr_d;
            resp_id_q     <= resp_id_d;
            resp_sum_q    <= resp_sum_d;
            grant_count_q <= grant_count_d;
`ifdef ADDER_ARB_FLAGS_EN
            resp_carry_q  <= resp_carry_d;
            resp_ovf_q    <= resp_ovf_d;
`endif
        end
    end

    assign resp_id     = resp_id_q;
    assign resp_sum    = resp_sum_q;
    assign grant_count = grant_count_q;
`ifdef ADDER_ARB_FLAGS_EN
    assign resp_carry  = resp_carry_q;
    assign resp_ovf    = resp_ovf_q;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Randomized + directed bench for adder_share_arbiter against a cycle-level behavioural model.
// Also exercises resp_carry / resp_ovf when compiled with ADDER_ARB_FLAGS_EN.
module tb_adder_share_arbiter;
    localparam int N  = 4;
    localparam int W  = 64;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N-1:0]     req_valid;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic             resp_valid;
    logic             resp_ready;
    logic [IW-1:0]    resp_id;
    logic [W-1:0]     resp_sum;
    logic [31:0]      grant_count;
`ifdef ADDER_ARB_FLAGS_EN
    logic             resp_carry;
    logic             resp_ovf;
`endif

    adder_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_a       (req_a),
        .req_b       (req_b),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_id     (resp_id),
        .resp_sum    (resp_sum),
`ifdef ADDER_ARB_FLAGS_EN
        .resp_carry  (resp_carry),
        .resp_ovf    (resp_ovf),
`endif
        .grant_count (grant_count)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Behavioural model of the observable state
    bit              m_valid;
    logic [W-1:0]    m_sum;
    int              m_id;
    int              m_ptr;
    longint unsigned m_cnt;
    bit              m_carry;
    bit              m_ovf;
    int              last_grant;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] op_a(input int i);
        return req_a[i*W +: W];
    endfunction

    function automatic logic [W-1:0] op_b(input int i);
        return req_b[i*W +: W];
    endfunction

    task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[i*W +: W] = a;
        req_b[i*W +: W] = b;
    endtask

    function automatic int ref_grant();
        if (reset || (m_valid && !resp_ready)) return -1;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [W-1:0] rnd64();
        case ($urandom_range(0, 5))
            0:       return {W{1'b1}};
            1:       return 64'h7FFF_FFFF_FFFF_FFFF;
            2:       return 64'h8000_0000_0000_0000;
            3:       return W'($urandom_range(0, 255));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    function automatic void model_reset();
        m_valid = 0; m_sum = '0; m_id = 0; m_ptr = 0; m_cnt = 0;
        m_carry = 0; m_ovf = 0;
    endfunction

    // Check everything at the current inputs, take one clock edge, advance the model.
    task automatic cycle();
        int           g;
        logic [N-1:0] exp_rdy;
        logic [W:0]   full;
        logic [W-1:0] a;
        logic [W-1:0] b;
        #1;
        g = ref_grant();
        exp_rdy = '0;
        if (g >= 0) exp_rdy[g] = 1'b1;
        check("req_ready", W'(req_ready), W'(exp_rdy));
        check("resp_valid", W'(resp_valid), W'(m_valid));
        check("resp_id", W'(resp_id), W'(m_id));
        check("resp_sum", resp_sum, m_sum);
        check("grant_count", W'(grant_count), W'(m_cnt));
`ifdef ADDER_ARB_FLAGS_EN
        check("resp_carry", W'(resp_carry), W'(m_carry));
        check("resp_ovf", W'(resp_ovf), W'(m_ovf));
`endif
        a = (g >= 0) ? op_a(g) : '0;
        b = (g >= 0) ? op_b(g) : '0;
        @(posedge clk);
        if (reset) begin
            model_reset();
        end else if (g >= 0) begin
            full    = {1'b0, a} + {1'b0, b};
            m_sum   = full[W-1:0];
            m_carry = full[W];
            m_ovf   = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
            m_id    = g;
            m_valid = 1;
            m_ptr   = (g + 1) % N;
            if (m_cnt < 64'hFFFF_FFFF) m_cnt++;
            $display("[TB] grant id=%0d a=%h b=%h sum=%h", g, a, b, m_sum);
        end else if (m_valid && resp_ready) begin
            m_valid = 0;
        end
        last_grant = g;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        resp_ready = 1'b0;
        model_reset();
        last_grant = -1;
        @(posedge clk);
        #1;
        cycle();
        check("rst_resp_valid", W'(resp_valid), '0);
        check("rst_resp_sum", resp_sum, '0);
        reset = 1'b0;

        // Single request: 5 + 7 from requester 0
        req_valid = 4'b0001;
        set_req(0, 64'd5, 64'd7);
        resp_ready = 1'b1;
        #1;
        check("tp1_ready", W'(req_ready), W'(4'b0001));
        cycle();
        req_valid = '0;
        check("tp1_sum", resp_sum, 64'd12);
        check("tp1_id", W'(resp_id), '0);
        check("tp1_count", W'(grant_count), 64'd1);
        cycle();

        // Round-robin order with all requesters busy
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, W'(i * 100), W'(i));
        req_valid = '1;
        resp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            cycle();
            check("rr_order", W'(last_grant), W'(k % N));
            check("rr_valid", W'(resp_valid), 64'd1);
        end

        // Back-pressure: result held while requester 1 waits
        do_reset();
        req_valid = 4'b0001;
        set_req(0, 64'd1, 64'd2);
        resp_ready = 1'b0;
        cycle();
        req_valid = 4'b0010;
        set_req(1, 64'd40, 64'd2);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("hold_ready", W'(req_ready), '0);
            check("hold_sum", resp_sum, 64'd3);
        end
        resp_ready = 1'b1;
        #1;
        check("release_ready", W'(req_ready), W'(4'b0010));
        cycle();
        req_valid = '0;
        check("release_sum", resp_sum, 64'd42);

        // Wrap-around and signed overflow corner cases
        req_valid = 4'b0001;
        set_req(0, {W{1'b1}}, 64'd1);
        cycle();
        check("wrap_sum", resp_sum, '0);
`ifdef ADDER_ARB_FLAGS_EN
        check("wrap_carry", W'(resp_carry), 64'd1);
        check("wrap_ovf", W'(resp_ovf), 64'd0);
`endif
        set_req(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1);
        cycle();
        req_valid = '0;
        check("ovf_sum", resp_sum, 64'h8000_0000_0000_0000);
`ifdef ADDER_ARB_FLAGS_EN
        check("ovf_flag", W'(resp_ovf), 64'd1);
        check("ovf_carry", W'(resp_carry), 64'd0);
`endif

        // Reset while FULL with every requester valid
        req_valid = '1;
        resp_ready = 1'b0;
        cycle();
        reset = 1'b1;
        cycle();
        check("midrst_valid", W'(resp_valid), '0);
        check("midrst_ready", W'(req_ready), '0);
        reset = 1'b0;
        resp_ready = 1'b1;
        #1;
        check("midrst_first", W'(req_ready), W'(4'b0001));
        cycle();

        // Random traffic: requesters hold operands until granted
        req_valid = '0;
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if (last_grant == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
                    req_valid[i] = 1'b1;
                    set_req(i, rnd64(), rnd64());
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            reset = ($urandom_range(0, 199) == 0);
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end
endmodule
